// File: rtl/leaf_result_collector_pkg.sv
// Shared defaults, FSM state type and the "no result" marker for the leaf result collector.
package leaf_result_collector_pkg;

  localparam int DEF_NUM_SRC = 3;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DEPTH   = 7;
  localparam int DEF_IDX_W   = 3;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  // A PE presents an all-zero word when a leaf produced nothing worth keeping.
  localparam logic [DEF_DATA_W-1:0] NO_RESULT = '0;

endpackage

// File: rtl/leaf_result_collector_if.sv
// Valid/ready result bus from the leaf-capable PEs into the collector.
interface leaf_result_collector_if #(
  parameter int NUM_SRC = leaf_result_collector_pkg::DEF_NUM_SRC,
  parameter int DATA_W  = leaf_result_collector_pkg::DEF_DATA_W
);
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_ready;

  // Result producers (PEs) drive valid/data and observe ready.
  modport master (output src_valid, output src_data, input src_ready);
  // The collector observes valid/data and drives ready.
  modport slave  (input src_valid, input src_data, output src_ready);
endinterface

// File: rtl/leaf_result_collector_rr_arbiter.sv
// Purely combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_vld
);

  // Scan N positions starting at ptr, wrapping modulo N; take the first request.
  always_comb begin
    int idx;
    // NOTE: every output gets a default before any conditional assignment, so no latch can be inferred.
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!grant_vld && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
        grant_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leaf_result_collector.sv
// Collects leaf results from several PEs in acceptance order into a small store,
// with round-robin fairness, a zero "no result" filter, a registered read port
// and done/full/overflow status.
module leaf_result_collector
  import leaf_result_collector_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [IDX_W-1:0]        expected_cnt,
  leaf_result_collector_if.slave  src,
  input  logic [IDX_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]       rd_data,
  output logic [IDX_W-1:0]        count,
  output logic                    full,
  output logic                    done,
  output logic                    overflow
);

  localparam int                PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [IDX_W-1:0]  DEPTH_C = IDX_W'(DEPTH);
  localparam logic [DATA_W-1:0] NO_RES  = DATA_W'(NO_RESULT);

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_W-1:0]     rd_data_q, rd_data_d;
  logic [DATA_W-1:0]     store_q [DEPTH];
  logic [DATA_W-1:0]     store_d [DEPTH];

  logic [NUM_SRC-1:0]    grant;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_vld;
  logic [DATA_W-1:0]     grant_data;
  logic                  ready_en;
  logic                  accept;
  logic                  store_en;

  rr_arbiter #(
    .N     (NUM_SRC),
    .PTR_W (PTR_W)
  ) u_arb (
    .req       (src.src_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Select the candidate word with a one-hot OR-mux so ready never depends on data.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) grant_data = src.src_data[i*DATA_W +: DATA_W];
    end
  end

  // Handshake qualifiers: acceptance only while collecting, not clearing, not in reset.
  always_comb begin
    ready_en = reset && !clear && (state_q == COLLECT);
    accept   = ready_en && grant_vld;
    store_en = accept && (grant_data != NO_RES) && (count_q < DEPTH_C);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!reset) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // FSM next state: the store that fills the last entry moves to FULL; only clear leaves it.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = COLLECT;
    end else begin
      unique case (state_q)
        COLLECT: if (store_en && (count_q == DEPTH_C - 1'b1)) state_d = FULL;
        FULL:    state_d = FULL;
        default: state_d = COLLECT;
      endcase
    end
  end

  // FSM outputs: the arbiter's grant becomes ready only when acceptance is enabled.
  always_comb begin
    src.src_ready = ready_en ? grant : '0;
  end

  // Datapath next state: pointer, occupancy, sticky overflow and the store write.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    store_d    = store_q;
    if (clear) begin
      rr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (accept) begin
        if (grant_idx == PTR_W'(NUM_SRC - 1)) rr_ptr_d = '0;
        else                                  rr_ptr_d = grant_idx + 1'b1;
      end
      if (store_en) begin
        store_d[count_q] = grant_data;
        count_d          = count_q + 1'b1;
      end
      if ((state_q == FULL) && grant_vld && (grant_data != NO_RES)) overflow_d = 1'b1;
    end
  end

  // Read port sees only committed entries; an entry written this cycle still reads as 0.
  always_comb begin
    rd_data_d = (rd_addr < count_q) ? store_q[rd_addr] : '0;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      // NOTE: the store is small and must read back as zero after reset, so every entry is reset explicitly.
      for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_data_q  <= rd_data_d;
      store_q    <= store_d;
    end
  end

  // Status outputs; done is combinational so it tracks expected_cnt changes immediately.
  always_comb begin
    rd_data  = rd_data_q;
    count    = count_q;
    full     = (count_q == DEPTH_C);
    done     = (expected_cnt != '0) && (count_q == expected_cnt);
    overflow = overflow_q;
  end

endmodule

// File: doc/leaf_result_collector.md
Name: leaf_result_collector

Overview:
- Collects 32-bit leaf results produced by the leaf-capable PEs of the tree scheduler and stores them in order into a small result store.
- Replaces ad-hoc per-slot result writes with a valid/ready round-robin arbiter: one accepted result per cycle, no loss under contention.
- Provides a registered read port, an occupancy count, and done/full/overflow status to the scheduler and to the host readout logic.

Parameters:
- NUM_SRC, 3, number of leaf result sources (the PE result outputs).
- DATA_W, 32, result word width.
- DEPTH, 7, result store entries (one per tree leaf).
- IDX_W, 3, width of count/address fields; must satisfy 2**IDX_W > DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- clear  in  1  synchronous restart of a collection run.
- expected_cnt  in  IDX_W  number of leaves expected this run (0 = no done detection).
- src_valid  in  NUM_SRC  bit i: source i presents a result.
- src_data  in  NUM_SRC*DATA_W  source i occupies bits [i*DATA_W +: DATA_W].
- src_ready  out  NUM_SRC  one-hot-or-zero acceptance; combinational.
- rd_addr  in  IDX_W  read index.
- rd_data  out  DATA_W  registered read data.
- count  out  IDX_W  entries stored.
- full  out  1  count == DEPTH.
- done  out  1  count == expected_cnt, with expected_cnt != 0.
- overflow  out  1  sticky: a nonzero result was presented while full.

Behaviour:
- Reset (reset=0, asynchronous): count=0, rr_ptr=0, rd_data=0, full=0, done=0, overflow=0, state=COLLECT, all store entries=0. src_ready=0 while reset is asserted.
- Handshake: a transfer occurs on a rising edge when src_valid[i] & src_ready[i] are both 1.
- A source holds its valid and data stable until accepted.
- src_ready depends only on src_valid, rr_ptr and state. There is no combinational path from src_data.
- Arbitration: grant goes to the first i with src_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... modulo NUM_SRC. At most one grant per cycle. After a transfer, rr_ptr <= (granted index + 1) mod NUM_SRC. rr_ptr is unchanged when there is no transfer.
- Zero filter: an accepted word equal to 0 is a "no result" marker. It is consumed (ready asserted, rr_ptr advances) but not stored, and count is unchanged.
- Store: an accepted nonzero word is written to store[count], and count increments in the same edge. Store writes are in acceptance order.
- FSM:
  - COLLECT: arbitration active. Go to FULL when a store makes count == DEPTH.
  - FULL: src_ready=0 for all sources. overflow <= 1 if any granted-candidate source is valid with nonzero data. The block stays in FULL until clear.
  - In both states, done is combinational from count and expected_cnt. Reaching done does not stop acceptance.
- clear: count=0, rr_ptr=0, overflow=0, state=COLLECT next cycle. Store contents are not erased.
  - clear has priority over a simultaneous transfer: src_ready is forced to 0 while clear=1, so nothing is lost or written.
- Read: rd_data <= (rd_addr < count) ? store[rd_addr] : 0, with one-cycle latency.
  - A read of the entry being written in the same cycle returns the old count view, i.e. 0.
- Width rules: count saturates at DEPTH and never wraps. expected_cnt > DEPTH means done never asserts.
- Reset mid-run: everything returns to reset values immediately. No partial handshake survives.

Decomposition:
- Shared package: DATA_W, DEPTH, IDX_W defaults; state enum {COLLECT, FULL}; the "no result" zero constant.
- Sub-module rr_arbiter (NUM_SRC requests, pointer in, one-hot grant out, pure combinational). It is reusable for PE input-port sharing.
- Store, counter, FSM and read port stay in leaf_result_collector.

Test Plan:
- Reset then single source: src_valid=3'b001, src_data[0]=32'hA5A5_0001 for one cycle -> src_ready=3'b001 that cycle; next cycle count=1. rd_addr=0 gives rd_data=32'hA5A5_0001 one cycle later.
- Contention, all three valid and held (data 32'h11, 32'h22, 32'h33): grants 001, 010, 100 on consecutive cycles -> store[0..2] = 11, 22, 33; count=3; rr_ptr back to 0.
- Zero filter: source 1 valid with 0, source 2 valid with 32'h77, rr_ptr=1 -> cycle 1 consumes the zero (count unchanged), cycle 2 stores 32'h77 at store[count].
- Done and full: expected_cnt=7, feed 7 nonzero words -> done=1 and full=1 together. An 8th valid word 32'hDEAD gets src_ready=0, overflow=1, count stays 7.
- Clear during contention: clear=1 with src_valid=3'b111 -> src_ready=000. Next cycle count=0, overflow=0, state COLLECT, rr_ptr=0. rd_addr=0 then returns 0.
- Async reset mid-transfer: assert reset=0 between edges while valid is held -> all outputs at reset values immediately. After release, first grant is source 0.
